motion_integrator: RTL and testbench
====================================

Name: motion_integrator

Overview:
Per-axis kinematic integrator for the teeter ball, successor to the single-stage velocity accumulator. On each physics tick it integrates signed acceleration into velocity and velocity into position. Velocity has saturation and optional friction; position has walls with clamp or bounce mode. It sits between the tilt-to-acceleration logic and the ball renderer, with one instance per axis.

Parameters:
ACCEL_W, 8, signed acceleration width
VEL_W, 32, internal signed velocity accumulator width
POS_W, 16, signed position width (pixels)
VELOCITY_SHIFT, 8, fractional bits of velocity; position step = v >>> VELOCITY_SHIFT
VMAX, 1048576, velocity magnitude limit; internal v saturates to [-VMAX, +VMAX]
FRICTION_SHIFT, 0, 0 disables friction; else friction term = v >>> FRICTION_SHIFT
POS_MIN, 0, lower wall
POS_MAX, 639, upper wall
WALL_MODE, 0, 0 = clamp (v forced to 0 at wall); 1 = bounce
BOUNCE_SHIFT, 2, bounce loss: v_out = -(v - (v >>> BOUNCE_SHIFT))

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
i_calc_time  in  1  one-cycle tick request
i_rst_v  in  1  synchronous velocity clear
i_rst_p  in  1  synchronous position load
i_pos_init  in  POS_W  value loaded by i_rst_p
i_accel  in  ACCEL_W  signed acceleration, sampled on accepted tick
o_velocity  out  VEL_W  v >>> VELOCITY_SHIFT, sign-extended
o_position  out  POS_W  current position
o_busy  out  1  update in progress
o_done  out  1  one-cycle pulse when update committed
o_hit_min  out  1  pulse with o_done when the lower wall was hit
o_hit_max  out  1  pulse with o_done when the upper wall was hit
o_overrun  out  1  sticky; set when a tick arrives while busy

Behaviour:
- RST_N low: v=0, position=POS_MIN, FSM=IDLE, all outputs 0 except o_position=POS_MIN. Takes effect immediately.
- FSM states: IDLE -> VEL -> POS -> WALL -> DONE -> IDLE, one state per cycle.
- IDLE: when i_calc_time=1, latch i_accel and go to VEL. o_busy=1 in VEL, POS, WALL and DONE.
- VEL: t = v + sext(accel) - (FRICTION_SHIFT ? v>>>FRICTION_SHIFT : 0). Compute at VEL_W+2 bits, saturate to ±VMAX, then register v.
- POS: p = position + (v >>> VELOCITY_SHIFT). Compute at POS_W+1 bits and hold in a temporary register.
- WALL:
  - p < POS_MIN: position=POS_MIN, hit_min flag set.
  - p > POS_MAX: position=POS_MAX, hit_max flag set.
  - At either wall: WALL_MODE 0 gives v=0; WALL_MODE 1 gives the bounce formula, negated and then saturated.
  - Otherwise position=p.
- DONE: o_done=1 and the hit flags are driven for this single cycle, then return to IDLE.
- Latency: tick accepted at edge 0; o_done is high in the cycle after edge 4. Maximum tick rate is 1 per 5 cycles.
- Tick while busy is dropped and o_overrun is set. o_overrun is cleared only by RST_N.
- i_rst_v or i_rst_p, in any state, aborts the update: FSM returns to IDLE, no o_done, tick discarded.
  - i_rst_v sets v=0. i_rst_p sets position=i_pos_init; i_pos_init is not range-checked.
  - Both together are both applied.
- Same-cycle i_rst_v/i_rst_p and i_calc_time in IDLE: reset wins and the tick is ignored.
- All arithmetic is two's complement. Right shifts are arithmetic, so -1 >>> 8 = -1.

Decomposition:
- Shared package motion_pkg holds the FSM state enum (IDLE, VEL, POS, WALL, DONE) and a saturating add function sat_add(a, b, limit).
- Sub-module: motion_wall_resolve, purely combinational. It takes p, v and the mode, and returns the clamped position, new v and the hit flags. This lets X and Y share one verified wall path.

Test Plan:
- Reset: RST_N low mid-update -> o_position=0, o_velocity=0, o_busy=0, o_done never pulses.
- FRICTION_SHIFT=0, i_accel=+16, 16 ticks spaced 5 cycles -> internal v=256, o_velocity=1, o_position=1 after tick 16; 16 o_done pulses.
- From reset, i_accel=-1, one tick -> p=-1, clamp to 0, o_hit_min=1 with o_done, v=0, o_velocity=0.
- VMAX=1000, i_accel=+127, 8 ticks -> internal v=1000, not 1016; v holds at 1000 on tick 9.
- Bounce, WALL_MODE=1, BOUNCE_SHIFT=2:
  - Setup: i_rst_p with i_pos_init=639, then i_accel=+127 for 3 ticks (v=127, 254, 381).
  - Tick 3: p=640 -> o_position=639, o_hit_max=1, internal v=-286.
- Overrun and abort:
  - i_calc_time high 2 consecutive cycles -> one update only, o_overrun=1.
  - i_rst_v in POS state -> v=0, no o_done, FSM in IDLE next cycle.

Source files
------------

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared FSM encoding and saturating arithmetic for the motion integrator
package motion_pkg;

   // Wide enough that velocity + acceleration - friction never wraps before saturation.
   localparam int SAT_W = 64;

   typedef enum logic [2:0] {IDLE, VEL, POS, WALL, DONE} motion_state_e;

   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input logic signed [SAT_W-1:0] limit
   );
      logic signed [SAT_W-1:0] s;
      s = a + b;
      if (s > limit) return limit;
      if (s < -limit) return -limit;
      return s;
   endfunction

endpackage

// File: rtl/motion_wall_resolve.sv
// rtl/motion_wall_resolve.sv - combinational wall clamp/bounce shared by every axis
module motion_wall_resolve #(
   parameter int VEL_W        = 32,
   parameter int POS_W        = 16,
   parameter int VMAX         = 1048576,
   parameter int POS_MIN      = 0,
   parameter int POS_MAX      = 639,
   parameter int BOUNCE_SHIFT = 2
) (
   input  logic signed [POS_W:0]   p_i,
   input  logic signed [VEL_W-1:0] v_i,
   input  logic                    mode_i,
   output logic signed [POS_W-1:0] pos_o,
   output logic signed [VEL_W-1:0] v_o,
   output logic                    hit_min_o,
   output logic                    hit_max_o
);
   import motion_pkg::*;

   logic signed [SAT_W-1:0] p_w;
   logic signed [SAT_W-1:0] v_w;
   logic                    lo;
   logic                    hi;

   always_comb begin
      p_w       = SAT_W'(p_i);
      v_w       = SAT_W'(v_i);
      lo        = (p_w < SAT_W'(POS_MIN));
      hi        = (p_w > SAT_W'(POS_MAX));
      hit_min_o = lo;
      hit_max_o = hi;
      pos_o     = p_i[POS_W-1:0];
      v_o       = v_i;
      if (lo) pos_o = POS_W'(POS_MIN);
      if (hi) pos_o = POS_W'(POS_MAX);
      // Bounce keeps 1 - 2^-BOUNCE_SHIFT of the speed and reverses direction.
      if (lo || hi) begin
         if (mode_i)
            v_o = VEL_W'(sat_add(SAT_W'(0), -(v_w - (v_w >>> BOUNCE_SHIFT)), SAT_W'(VMAX)));
         else
            v_o = '0;
      end
   end

endmodule

// File: rtl/motion_integrator.sv
// rtl/motion_integrator.sv - per-axis velocity/position integrator with saturation, friction and walls
module motion_integrator #(
   parameter int ACCEL_W        = 8,
   parameter int VEL_W          = 32,
   parameter int POS_W          = 16,
   parameter int VELOCITY_SHIFT = 8,
   parameter int VMAX           = 1048576,
   parameter int FRICTION_SHIFT = 0,
   parameter int POS_MIN        = 0,
   parameter int POS_MAX        = 639,
   parameter int WALL_MODE      = 0,
   parameter int BOUNCE_SHIFT   = 2
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      i_calc_time,
   input  logic                      i_rst_v,
   input  logic                      i_rst_p,
   input  logic signed [POS_W-1:0]   i_pos_init,
   input  logic signed [ACCEL_W-1:0] i_accel,
   output logic signed [VEL_W-1:0]   o_velocity,
   output logic signed [POS_W-1:0]   o_position,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_hit_min,
   output logic                      o_hit_max,
   output logic                      o_overrun
);
   import motion_pkg::*;

   motion_state_e             state_q;
   logic signed [ACCEL_W-1:0] accel_q;
   logic signed [VEL_W-1:0]   v_q;
   logic signed [VEL_W-1:0]   v_d;
   logic signed [VEL_W-1:0]   wall_v_d;
   logic signed [POS_W-1:0]   pos_q;
   logic signed [POS_W-1:0]   wall_pos_d;
   logic signed [POS_W:0]     p_q;
   logic signed [POS_W:0]     p_d;
   logic                      wall_min_d;
   logic                      wall_max_d;
   logic                      pend_min_q;
   logic                      pend_max_q;
   logic                      done_q;
   logic                      hit_min_q;
   logic                      hit_max_q;
   logic                      overrun_q;
   logic                      wall_mode;

   assign wall_mode = (WALL_MODE != 0);

   always_comb begin
      v_d = VEL_W'(sat_add(SAT_W'(v_q) - ((FRICTION_SHIFT == 0) ? SAT_W'(0)
                                                               : (SAT_W'(v_q) >>> FRICTION_SHIFT)),
                           SAT_W'(accel_q), SAT_W'(VMAX)));
      p_d = {pos_q[POS_W-1], pos_q} + (POS_W+1)'(v_q >>> VELOCITY_SHIFT);
   end

   motion_wall_resolve #(
      .VEL_W        (VEL_W),
      .POS_W        (POS_W),
      .VMAX         (VMAX),
      .POS_MIN      (POS_MIN),
      .POS_MAX      (POS_MAX),
      .BOUNCE_SHIFT (BOUNCE_SHIFT)
   ) u_wall (
      .p_i       (p_q),
      .v_i       (v_q),
      .mode_i    (wall_mode),
      .pos_o     (wall_pos_d),
      .v_o       (wall_v_d),
      .hit_min_o (wall_min_d),
      .hit_max_o (wall_max_d)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         accel_q    <= '0;
         v_q        <= '0;
         pos_q      <= POS_W'(POS_MIN);
         p_q        <= '0;
         pend_min_q <= 1'b0;
         pend_max_q <= 1'b0;
         done_q     <= 1'b0;
         hit_min_q  <= 1'b0;
         hit_max_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         hit_min_q <= 1'b0;
         hit_max_q <= 1'b0;
         if (i_calc_time && state_q != IDLE) overrun_q <= 1'b1;
         // Either clear aborts whatever update is in flight and swallows a same-cycle tick.
         if (i_rst_v || i_rst_p) begin
            state_q <= IDLE;
            if (i_rst_v) v_q <= '0;
            if (i_rst_p) pos_q <= i_pos_init;
         end else begin
            case (state_q)
               IDLE: begin
                  if (i_calc_time) begin
                     accel_q <= i_accel;
                     state_q <= VEL;
                  end
               end
               VEL: begin
                  v_q     <= v_d;
                  state_q <= POS;
               end
               POS: begin
                  p_q     <= p_d;
                  state_q <= WALL;
               end
               WALL: begin
                  pos_q      <= wall_pos_d;
                  v_q        <= wall_v_d;
                  pend_min_q <= wall_min_d;
                  pend_max_q <= wall_max_d;
                  state_q    <= DONE;
               end
               DONE: begin
                  done_q    <= 1'b1;
                  hit_min_q <= pend_min_q;
                  hit_max_q <= pend_max_q;
                  state_q   <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_velocity = v_q >>> VELOCITY_SHIFT;
   assign o_position = pos_q;
   assign o_busy     = (state_q != IDLE);
   assign o_done     = done_q;
   assign o_hit_min  = hit_min_q;
   assign o_hit_max  = hit_max_q;
   assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_motion_integrator.sv
// tb/tb_motion_integrator.sv - randomized and directed bench for motion_integrator against an arithmetic model
module tb_motion_integrator;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               calc = 1'b0;
   logic               rst_v = 1'b0;
   logic               rst_p = 1'b0;
   logic signed [15:0] pos_init = '0;
   logic signed [7:0]  accel = '0;

   logic signed [31:0] vel_w [3];
   logic signed [15:0] pos_w [3];
   logic               busy_w [3];
   logic               done_w [3];
   logic               hmin_w [3];
   logic               hmax_w [3];
   logic               ovr_w [3];

   // 0: clamp, 1: bounce with VMAX=1000, 2: clamp with friction
   longint p_vmax [3] = '{1048576, 1000, 1048576};
   int     p_fs   [3] = '{0, 0, 3};
   int     p_mode [3] = '{0, 1, 0};

   longint m_v [3];
   longint m_p [3];
   bit     m_hmin [3];
   bit     m_hmax [3];
   bit     m_ovr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   motion_integrator #(.VMAX(1048576), .FRICTION_SHIFT(0), .WALL_MODE(0)) u_clamp (
      .CLK(clk), .RST_N(rst_n), .i_calc_time(calc), .i_rst_v(rst_v), .i_rst_p(rst_p),
      .i_pos_init(pos_init), .i_accel(accel), .o_velocity(vel_w[0]), .o_position(pos_w[0]),
      .o_busy(busy_w[0]), .o_done(done_w[0]), .o_hit_min(hmin_w[0]), .o_hit_max(hmax_w[0]),
      .o_overrun(ovr_w[0]));

   motion_integrator #(.VMAX(1000), .FRICTION_SHIFT(0), .WALL_MODE(1)) u_bounce (
      .CLK(clk), .RST_N(rst_n), .i_calc_time(calc), .i_rst_v(rst_v), .i_rst_p(rst_p),
      .i_pos_init(pos_init), .i_accel(accel), .o_velocity(vel_w[1]), .o_position(pos_w[1]),
      .o_busy(busy_w[1]), .o_done(done_w[1]), .o_hit_min(hmin_w[1]), .o_hit_max(hmax_w[1]),
      .o_overrun(ovr_w[1]));

   motion_integrator #(.VMAX(1048576), .FRICTION_SHIFT(3), .WALL_MODE(0)) u_fric (
      .CLK(clk), .RST_N(rst_n), .i_calc_time(calc), .i_rst_v(rst_v), .i_rst_p(rst_p),
      .i_pos_init(pos_init), .i_accel(accel), .o_velocity(vel_w[2]), .o_position(pos_w[2]),
      .o_busy(busy_w[2]), .o_done(done_w[2]), .o_hit_min(hmin_w[2]), .o_hit_max(hmax_w[2]),
      .o_overrun(ovr_w[2]));

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint clampv(input longint x, input longint lim);
      if (x > lim) return lim;
      if (x < -lim) return -lim;
      return x;
   endfunction

   task automatic model_reset_all();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 0;
         m_p[k] = 0;
      end
      m_ovr = 1'b0;
   endtask

   task automatic model_tick(input longint a);
      longint v;
      longint p;
      for (int k = 0; k < 3; k++) begin
         v = m_v[k] + a - ((p_fs[k] != 0) ? (m_v[k] >>> p_fs[k]) : 0);
         v = clampv(v, p_vmax[k]);
         p = m_p[k] + (v >>> 8);
         m_hmin[k] = (p < 0);
         m_hmax[k] = (p > 639);
         if (m_hmin[k] || m_hmax[k]) begin
            p = m_hmin[k] ? 0 : 639;
            v = (p_mode[k] != 0) ? clampv(-(v - (v >>> 2)), p_vmax[k]) : 0;
         end
         m_v[k] = v;
         m_p[k] = p;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_vel%0d", tag, k), vel_w[k], m_v[k] >>> 8);
         check($sformatf("%s_pos%0d", tag, k), pos_w[k], m_p[k]);
         check($sformatf("%s_ovr%0d", tag, k), ovr_w[k], m_ovr);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit v, input bit p, input int init, input bit with_tick);
      rst_v    = v;
      rst_p    = p;
      pos_init = 16'(init);
      calc     = with_tick;
      accel    = 8'sd5;
      step();
      rst_v = 1'b0;
      rst_p = 1'b0;
      calc  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (v) m_v[k] = 0;
         if (p) m_p[k] = init;
      end
      if (with_tick) check("load_tick_ignored_busy", busy_w[0], 0);
   endtask

   task automatic do_tick(input string tag, input int a, output bit seen);
      int lat;
      seen  = 1'b0;
      lat   = 0;
      accel = 8'(a);
      calc  = 1'b1;
      step();
      calc = 1'b0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         step();
         if (done_w[0]) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_latency"}, lat, 4);
         model_tick(a);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_done%0d", tag, k), done_w[k], 1);
            check($sformatf("%s_hmin%0d", tag, k), hmin_w[k], m_hmin[k]);
            check($sformatf("%s_hmax%0d", tag, k), hmax_w[k], m_hmax[k]);
         end
         check({tag, "_busy"}, busy_w[0], 0);
         check_all(tag);
      end
   endtask

   task automatic quiet(input string tag, input int n);
      int c;
      c = 0;
      repeat (n) begin
         step();
         if (done_w[0] || done_w[1] || done_w[2]) c++;
      end
      check(tag, c, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit seen;
      int dones;
      int r;

      model_reset_all();
      repeat (2) step();
      check("rst_pos", pos_w[0], 0);
      check("rst_vel", vel_w[0], 0);
      check("rst_busy", busy_w[0], 0);
      check("rst_done", done_w[0], 0);
      check("rst_ovr", ovr_w[0], 0);
      rst_n = 1'b1;
      step();

      // asynchronous reset in the middle of an update
      load(1'b0, 1'b1, 100, 1'b0);
      check("preload_pos", pos_w[0], 100);
      accel = 8'sd50;
      calc  = 1'b1;
      step();
      calc = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_pos", pos_w[0], 0);
      check("arst_vel", vel_w[0], 0);
      check("arst_busy", busy_w[0], 0);
      step();
      rst_n = 1'b1;
      model_reset_all();
      quiet("arst_no_done", 10);

      // constant +16: velocity reaches 256 after 16 ticks
      dones = 0;
      for (int i = 0; i < 16; i++) begin
         do_tick("acc16", 16, seen);
         dones += int'(seen);
      end
      check("acc16_dones", dones, 16);
      check("acc16_vel_final", vel_w[0], 1);
      check("acc16_pos_final", pos_w[0], 1);

      // reset with a same-cycle tick, then a single -1 tick into the lower wall
      load(1'b1, 1'b1, 0, 1'b1);
      check("clear_vel", vel_w[0], 0);
      do_tick("neg1", -1, seen);
      check("neg1_hit_min", hmin_w[0], 1);
      check("neg1_pos", pos_w[0], 0);
      check("neg1_vel", vel_w[0], 0);

      // saturation at VMAX=1000 on the bounce instance
      load(1'b1, 1'b1, 0, 1'b0);
      for (int i = 0; i < 8; i++) do_tick("vmax", 127, seen);
      check("vmax_vel8", vel_w[1], 3);
      check("vmax_pos8", pos_w[1], 12);
      do_tick("vmax9", 127, seen);
      check("vmax_vel9", vel_w[1], 3);
      check("vmax_pos9", pos_w[1], 15);

      // upper wall: bounce on instance 1, clamp on instance 0
      load(1'b1, 1'b1, 639, 1'b0);
      for (int i = 0; i < 3; i++) do_tick("bounce", 127, seen);
      check("bounce_pos", pos_w[1], 639);
      check("bounce_hit_max", hmax_w[1], 1);
      check("bounce_vel", vel_w[1], -2);
      check("clampmax_pos", pos_w[0], 639);
      check("clampmax_hit_max", hmax_w[0], 1);
      check("clampmax_vel", vel_w[0], 0);
      do_tick("bounce_after", 0, seen);
      check("bounce_after_pos", pos_w[1], 637);

      // tick held for two cycles: one update, sticky overrun
      load(1'b1, 1'b1, 300, 1'b0);
      accel = 8'sd20;
      calc  = 1'b1;
      step();
      step();
      calc  = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done_w[0]) dones++;
      end
      check("ovr_dones", dones, 1);
      model_tick(20);
      m_ovr = 1'b1;
      check_all("ovr");

      // velocity clear while in POS aborts the update
      accel = 8'sd40;
      calc  = 1'b1;
      step();
      calc  = 1'b0;
      step();
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      check("abort_busy", busy_w[0], 0);
      check("abort_vel", vel_w[0], 0);
      for (int k = 0; k < 3; k++) m_v[k] = 0;
      quiet("abort_no_done", 10);
      check_all("abort");

      // randomized ticks with occasional clears and idle gaps
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) load(1'b1, 1'b0, 0, 1'b0);
         else if (r == 1) load(1'b0, 1'b1, int'($urandom_range(0, 639)), 1'b0);
         repeat ($urandom_range(0, 2)) step();
         do_tick("rand", int'($urandom_range(0, 255)) - 128, seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
